// File: rtl/apb_rr_arbiter.sv
// Four-requester round-robin arbiter driving a single APB master port.
// Optional ACCESS timeout (16 wait cycles, err + done) enabled by defining APB_ARB_TIMEOUT_EN.
module apb_rr_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic               pclk,
    input  logic               preset,
    input  logic [3:0]         req,
    input  logic [3:0]         req_rw,
    input  logic [4*WIDTH-1:0] req_addr,
    input  logic [4*WIDTH-1:0] req_wdata,
    output logic [3:0]         gnt,
    output logic [3:0]         done,
    output logic [WIDTH-1:0]   rdata,
    output logic               err,
    output logic               psel,
    output logic               penable,
    output logic               pwrite,
    output logic [WIDTH-1:0]   paddr,
    output logic [WIDTH-1:0]   pwdata,
    input  logic [WIDTH-1:0]   prdata,
    input  logic               pready
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [1:0] winner;
    logic [1:0] win_sel;
    logic       timeout;

    // First asserted request at or above the pointer, wrapping 3 -> 0.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic       found;
        rr_pick = p;
        found   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = p + 2'(k);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    assign win_sel = rr_pick(req, ptr);

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state   <= IDLE;
            ptr     <= 2'd0;
            winner  <= 2'd0;
            gnt     <= 4'd0;
            done    <= 4'd0;
            rdata   <= '0;
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
        end else begin
            done <= 4'd0;
            case (state)
                IDLE: begin
                    penable <= 1'b0;
                    if (|req) begin
                        state  <= SETUP;
                        winner <= win_sel;
                        gnt    <= 4'b0001 << win_sel;
                        psel   <= 1'b1;
                        pwrite <= req_rw[win_sel];
                        paddr  <= req_addr[win_sel*WIDTH +: WIDTH];
                        pwdata <= req_wdata[win_sel*WIDTH +: WIDTH];
                    end else begin
                        gnt  <= 4'd0;
                        psel <= 1'b0;
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    penable <= 1'b1;
                end
                ACCESS: begin
                    // A timeout completes like a normal transfer but never loads rdata.
                    if (pready || timeout) begin
                        state   <= IDLE;
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        gnt     <= 4'd0;
                        done    <= gnt;
                        ptr     <= winner + 2'd1;
                        if (pready && !pwrite)
                            rdata <= prdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    logic [3:0] wait_cnt;

    assign timeout = (state == ACCESS) && !pready && (wait_cnt == 4'hf);

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            wait_cnt <= 4'd0;
            err      <= 1'b0;
        end else begin
            err <= timeout;
            if (state == SETUP)
                wait_cnt <= 4'd0;
            else if (state == ACCESS && !pready)
                wait_cnt <= wait_cnt + 4'd1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed bench for apb_rr_arbiter: write, waited read, round-robin order, fairness,
// reset mid-transfer, and the ACCESS timeout (or its absence) depending on APB_ARB_TIMEOUT_EN.
module tb_apb_rr_arbiter;

    localparam int WIDTH = 8;

    logic               pclk = 1'b0;
    logic               preset = 1'b0;
    logic [3:0]         req = '0;
    logic [3:0]         req_rw = '0;
    logic [4*WIDTH-1:0] req_addr = '0;
    logic [4*WIDTH-1:0] req_wdata = '0;
    logic [3:0]         gnt;
    logic [3:0]         done;
    logic [WIDTH-1:0]   rdata;
    logic               err;
    logic               psel;
    logic               penable;
    logic               pwrite;
    logic [WIDTH-1:0]   paddr;
    logic [WIDTH-1:0]   pwdata;
    logic [WIDTH-1:0]   prdata = '0;
    logic               pready = 1'b0;

    int total = 0;
    int bad   = 0;

    apb_rr_arbiter #(.WIDTH(WIDTH)) dut (
        .pclk(pclk), .preset(preset), .req(req), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
        .rdata(rdata), .err(err), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    logic [3:0] rr_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        // Asynchronous reset, checked before any clock edge
        #2 preset = 1'b1;
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_done", done, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_err", err, 0);
        chk("rst_paddr", paddr, 0);
        tick();
        tick();
        preset = 1'b0;

        // Single write from requester 0
        req = 4'b0001; req_rw = 4'b0001;
        req_addr[7:0] = 8'h12; req_wdata[7:0] = 8'h5A; pready = 1'b1;
        tick();
        chk("wr_psel", psel, 1);
        chk("wr_penable0", penable, 0);
        chk("wr_paddr", paddr, 8'h12);
        chk("wr_pwdata", pwdata, 8'h5A);
        chk("wr_pwrite", pwrite, 1);
        chk("wr_gnt", gnt, 4'b0001);
        tick();
        chk("wr_penable1", penable, 1);
        chk("wr_done_early", done, 0);
        tick();
        chk("wr_done", done, 4'b0001);
        chk("wr_psel_off", psel, 0);
        chk("wr_gnt_off", gnt, 0);
        chk("wr_rdata_kept", rdata, 0);
        chk("wr_err", err, 0);
        req = 4'b0000;
        tick();
        chk("idle_done", done, 0);
        chk("idle_paddr_hold", paddr, 8'h12);
        chk("idle_psel", psel, 0);

        // Read from requester 2 with two wait states (ptr is now 1)
        req = 4'b0100; req_rw = 4'b0000;
        req_addr[23:16] = 8'h30; prdata = 8'hC3; pready = 1'b0;
        tick();
        chk("rd_gnt", gnt, 4'b0100);
        chk("rd_paddr", paddr, 8'h30);
        chk("rd_pwrite", pwrite, 0);
        tick();
        chk("rd_pen_a", penable, 1);
        req_addr[23:16] = 8'h77;
        tick();
        chk("rd_pen_b", penable, 1);
        chk("rd_addr_latched", paddr, 8'h30);
        chk("rd_wait_done", done, 0);
        tick();
        chk("rd_pen_c", penable, 1);
        pready = 1'b1;
        tick();
        chk("rd_done", done, 4'b0100);
        chk("rd_rdata", rdata, 8'hC3);
        chk("rd_pen_off", penable, 0);
        req = 4'b0000;
        tick();

        // Reset in the middle of a waited ACCESS (ptr is now 3)
        req = 4'b1000; pready = 1'b0;
        tick();
        chk("ra_gnt", gnt, 4'b1000);
        tick();
        tick();
        chk("ra_in_access", penable, 1);
        #2 preset = 1'b1;
        #1;
        chk("ra_psel", psel, 0);
        chk("ra_penable", penable, 0);
        chk("ra_gnt_off", gnt, 0);
        tick();
        chk("ra_no_done", done, 0);
        preset = 1'b0;

        // Round-robin with all requests held, starting from requester 0 after reset
        req = 4'b1111; pready = 1'b1; prdata = 8'hC3;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_gnt", gnt, rr_order[i]);
            chk("rr_setup_pen", penable, 0);
            tick();
            chk("rr_access_pen", penable, 1);
            tick();
            chk("rr_done", done, rr_order[i]);
            chk("rr_idle_psel", psel, 0);
        end

        // Move ptr to 2, then req=0011 must grant 0 before 1
        req = 4'b0010;
        tick();
        chk("fs_gnt1", gnt, 4'b0010);
        tick();
        tick();
        chk("fs_done1", done, 4'b0010);
        req = 4'b0011;
        tick();
        chk("fs_gnt_first", gnt, 4'b0001);
        tick();
        tick();
        chk("fs_done_first", done, 4'b0001);
        req = 4'b0010;
        tick();
        chk("fs_gnt_second", gnt, 4'b0010);
        tick();
        tick();
        chk("fs_done_second", done, 4'b0010);
        req = 4'b0000;
        tick();

        // Stalled slave: timeout when enabled, indefinite wait otherwise
        req = 4'b0001; req_rw = 4'b0000; pready = 1'b0; prdata = 8'h99;
        tick();
        tick();
        chk("to_access", penable, 1);
`ifdef APB_ARB_TIMEOUT_EN
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("to_wait_done", done, 0);
            chk("to_wait_err", err, 0);
        end
        tick();
        chk("to_done", done, 4'b0001);
        chk("to_err", err, 1);
        chk("to_rdata_kept", rdata, 8'hC3);
        chk("to_psel_off", psel, 0);
        req = 4'b0000;
        tick();
        chk("to_err_pulse", err, 0);
        chk("to_idle", psel, 0);
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("nt_wait_done", done, 0);
            chk("nt_err", err, 0);
        end
        chk("nt_still_access", penable, 1);
        pready = 1'b1;
        tick();
        chk("nt_done", done, 4'b0001);
        chk("nt_err_done", err, 0);
        chk("nt_rdata", rdata, 8'h99);
        req = 4'b0000;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
